btn_gesture_multi: RTL and testbench



---
 rtl/btn_gesture_pkg.sv | 26 ++
 rtl/btn_gesture_ch.sv | 177 +++++++++++++++++
 rtl/btn_gesture_multi.sv | 71 +++++++
 tb/tb_btn_gesture_multi.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/btn_gesture_pkg.sv
// Shared state encoding, default timing constants and timer sizing for the button gesture classifier.
package btn_gesture_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PRESSED = 2'd1;
    localparam logic [1:0] ST_GAP     = 2'd2;
    localparam logic [1:0] ST_HELD    = 2'd3;

    localparam int DEF_CHANNELS    = 4;
    localparam int DEF_CLK_PER_US  = 125;
    localparam int DEF_DEBOUNCE_US = 10_000;
    localparam int DEF_HOLD_US     = 700_000;
    localparam int DEF_GAP_US      = 150_000;
    localparam int DEF_REPEAT_US   = 200_000;
    localparam int DEF_MAX_TAPS    = 3;

    // Wide enough to hold the largest threshold the per-channel timer is compared against.
    function automatic int timer_width(input int hold_us, input int gap_us, input int repeat_us);
        int m;
        m = hold_us;
        if (gap_us > m) m = gap_us;
        if (repeat_us > m) m = repeat_us;
        return (m > 0) ? $clog2(m + 1) : 1;
    endfunction

endpackage

// File: rtl/btn_gesture_ch.sv
// One button channel: synchroniser, debouncer, saturating us timer and gesture FSM.
// Event pulses are registered one cycle after the deciding edge or tick; there is no backpressure.
module btn_gesture_ch
    import btn_gesture_pkg::*;
#(
    parameter int DEBOUNCE_US = DEF_DEBOUNCE_US,
    parameter int HOLD_US     = DEF_HOLD_US,
    parameter int GAP_US      = DEF_GAP_US,
    parameter int REPEAT_US   = DEF_REPEAT_US,
    parameter int MAX_TAPS    = DEF_MAX_TAPS,
    parameter int CW          = $clog2(DEF_MAX_TAPS + 1)
) (
    input  logic          clk,
    input  logic          reset_p,
    input  logic          us_tick,
    input  logic          btn,
    input  logic          en,
    output logic          tap_valid,
    output logic [CW-1:0] tap_count,
    output logic          long_start,
    output logic          long_repeat,
    output logic          long_release,
    output logic          busy
);

    localparam int DBW = (DEBOUNCE_US > 0) ? $clog2(DEBOUNCE_US + 1) : 1;
    localparam int TW  = timer_width(HOLD_US, GAP_US, REPEAT_US);
    localparam logic [TW-1:0] TMAX = {TW{1'b1}};

    logic           sync1_q, sync2_q;
    logic           db_level_q, db_level_d;
    logic [DBW-1:0] db_cnt_q, db_cnt_d;
    logic           rise_q, rise_d, fall_q, fall_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic [1:0]     state_q, state_d;
    logic [CW-1:0]  taps_q, taps_d;
    logic [CW-1:0]  tap_count_q, tap_count_d;
    logic           tap_valid_q, tap_valid_d;
    logic           long_start_q, long_start_d;
    logic           long_repeat_q, long_repeat_d;
    logic           long_release_q, long_release_d;
    logic           hold_hit, gap_hit, rep_hit, rep_clr;

    // Debounce: count ticks while the synchronised input disagrees; any agreement restarts the count.
    always_comb begin
        db_level_d = db_level_q;
        db_cnt_d   = db_cnt_q;
        rise_d     = 1'b0;
        fall_d     = 1'b0;
        if (sync2_q == db_level_q) begin
            db_cnt_d = '0;
        end else if (us_tick) begin
            if (int'(db_cnt_q) + 1 >= DEBOUNCE_US) begin
                db_level_d = sync2_q;
                db_cnt_d   = '0;
                rise_d     = sync2_q;
                fall_d     = ~sync2_q;
            end else begin
                db_cnt_d = db_cnt_q + DBW'(1);
            end
        end
    end

    // Thresholds fire on the tick that brings the timer up to the limit.
    assign hold_hit = us_tick && (int'(timer_q) + 1 >= HOLD_US);
    assign gap_hit  = us_tick && (int'(timer_q) + 1 >= GAP_US);
    assign rep_hit  = us_tick && (int'(timer_q) + 1 >= REPEAT_US);

    always_comb begin
        state_d        = state_q;
        taps_d         = taps_q;
        tap_count_d    = tap_count_q;
        tap_valid_d    = 1'b0;
        long_start_d   = 1'b0;
        long_repeat_d  = 1'b0;
        long_release_d = 1'b0;
        rep_clr        = 1'b0;
        if (!en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (rise_q) begin
                        state_d = ST_PRESSED;
                        taps_d  = CW'(1);
                    end
                end
                ST_PRESSED: begin
                    if (fall_q) begin
                        if (int'(taps_q) >= MAX_TAPS) begin
                            tap_valid_d = 1'b1;
                            tap_count_d = taps_q;
                            state_d     = ST_IDLE;
                        end else begin
                            state_d = ST_GAP;
                        end
                    end else if (hold_hit) begin
                        long_start_d = 1'b1;
                        tap_count_d  = taps_q;
                        state_d      = ST_HELD;
                    end
                end
                ST_GAP: begin
                    if (rise_q) begin
                        state_d = ST_PRESSED;
                        taps_d  = taps_q + CW'(1);
                    end else if (gap_hit) begin
                        tap_valid_d = 1'b1;
                        tap_count_d = taps_q;
                        state_d     = ST_IDLE;
                    end
                end
                ST_HELD: begin
                    if (fall_q) begin
                        long_release_d = 1'b1;
                        state_d        = ST_IDLE;
                    end else if ((REPEAT_US > 0) && rep_hit) begin
                        long_repeat_d = 1'b1;
                        rep_clr       = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        timer_d = timer_q;
        if ((state_d != state_q) || rep_clr) begin
            timer_d = '0;
        end else if (us_tick && (timer_q != TMAX)) begin
            timer_d = timer_q + TW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            sync1_q        <= 1'b0;
            sync2_q        <= 1'b0;
            db_level_q     <= 1'b0;
            db_cnt_q       <= '0;
            rise_q         <= 1'b0;
            fall_q         <= 1'b0;
            timer_q        <= '0;
            state_q        <= ST_IDLE;
            taps_q         <= '0;
            tap_count_q    <= '0;
            tap_valid_q    <= 1'b0;
            long_start_q   <= 1'b0;
            long_repeat_q  <= 1'b0;
            long_release_q <= 1'b0;
        end else begin
            sync1_q        <= btn;
            sync2_q        <= sync1_q;
            db_level_q     <= db_level_d;
            db_cnt_q       <= db_cnt_d;
            rise_q         <= rise_d;
            fall_q         <= fall_d;
            timer_q        <= timer_d;
            state_q        <= state_d;
            taps_q         <= taps_d;
            tap_count_q    <= tap_count_d;
            tap_valid_q    <= tap_valid_d;
            long_start_q   <= long_start_d;
            long_repeat_q  <= long_repeat_d;
            long_release_q <= long_release_d;
        end
    end

    assign tap_valid    = tap_valid_q;
    assign tap_count    = tap_count_q;
    assign long_start   = long_start_q;
    assign long_repeat  = long_repeat_q;
    assign long_release = long_release_q;
    assign busy         = (state_q != ST_IDLE);

endmodule

// File: rtl/btn_gesture_multi.sv
// Multi-channel button gesture classifier: shared 1 us tick plus independent per-channel classifiers.
// Pulses are registered one cycle after the deciding event; outputs are fire-and-forget with no backpressure.
module btn_gesture_multi
    import btn_gesture_pkg::*;
#(
    parameter int CHANNELS    = DEF_CHANNELS,
    parameter int CLK_PER_US  = DEF_CLK_PER_US,
    parameter int DEBOUNCE_US = DEF_DEBOUNCE_US,
    parameter int HOLD_US     = DEF_HOLD_US,
    parameter int GAP_US      = DEF_GAP_US,
    parameter int REPEAT_US   = DEF_REPEAT_US,
    parameter int MAX_TAPS    = DEF_MAX_TAPS
) (
    input  logic                                       clk,
    input  logic                                       reset_p,
    input  logic [CHANNELS-1:0]                        btn,
    input  logic [CHANNELS-1:0]                        en,
    output logic [CHANNELS-1:0]                        tap_valid,
    output logic [CHANNELS*$clog2(MAX_TAPS+1)-1:0]     tap_count,
    output logic [CHANNELS-1:0]                        long_start,
    output logic [CHANNELS-1:0]                        long_repeat,
    output logic [CHANNELS-1:0]                        long_release,
    output logic [CHANNELS-1:0]                        busy
);

    localparam int CW  = $clog2(MAX_TAPS + 1);
    localparam int TCW = $clog2(CLK_PER_US + 1);

    logic [TCW-1:0] tick_cnt_q, tick_cnt_d;
    logic           us_tick_q, us_tick_d;

    // Free-running regardless of en so every channel sees the same time base.
    always_comb begin
        us_tick_d  = (tick_cnt_q == TCW'(CLK_PER_US - 1));
        tick_cnt_d = us_tick_d ? '0 : tick_cnt_q + TCW'(1);
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            tick_cnt_q <= '0;
            us_tick_q  <= 1'b0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            us_tick_q  <= us_tick_d;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        btn_gesture_ch #(
            .DEBOUNCE_US (DEBOUNCE_US),
            .HOLD_US     (HOLD_US),
            .GAP_US      (GAP_US),
            .REPEAT_US   (REPEAT_US),
            .MAX_TAPS    (MAX_TAPS),
            .CW          (CW)
        ) u_ch (
            .clk          (clk),
            .reset_p      (reset_p),
            .us_tick      (us_tick_q),
            .btn          (btn[i]),
            .en           (en[i]),
            .tap_valid    (tap_valid[i]),
            .tap_count    (tap_count[i*CW +: CW]),
            .long_start   (long_start[i]),
            .long_repeat  (long_repeat[i]),
            .long_release (long_release[i]),
            .busy         (busy[i])
        );
    end

endmodule

// File: tb/tb_btn_gesture_multi.sv
// Scoreboard bench: gesture tasks push expected events per channel, a monitor pops them as pulses appear.
module tb_btn_gesture_multi;

    localparam int CH   = 2;
    localparam int CPU  = 2;
    localparam int DEB  = 2;
    localparam int HOLD = 50;
    localparam int GAP  = 20;
    localparam int REP  = 15;
    localparam int MAXT = 3;
    localparam int CW   = 2;
    localparam int SLOP_LO = 2;
    localparam int SLOP_HI = 16;

    localparam int K_TAP = 0, K_START = 1, K_REP = 2, K_REL = 3;

    logic               clk = 1'b0;
    logic               reset_p;
    logic [CH-1:0]      btn, en;
    logic [CH-1:0]      tap_valid, long_start, long_repeat, long_release, busy;
    logic [CH*CW-1:0]   tap_count;
    logic               b0, b1, e0, e1;

    assign btn = {b1, b0};
    assign en  = {e1, e0};

    btn_gesture_multi #(
        .CHANNELS(CH), .CLK_PER_US(CPU), .DEBOUNCE_US(DEB), .HOLD_US(HOLD),
        .GAP_US(GAP), .REPEAT_US(REP), .MAX_TAPS(MAXT)
    ) dut (
        .clk(clk), .reset_p(reset_p), .btn(btn), .en(en),
        .tap_valid(tap_valid), .tap_count(tap_count), .long_start(long_start),
        .long_repeat(long_repeat), .long_release(long_release), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int kind;
        int cnt;
        int lo;
        int hi;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic check_eq(string name, int act, int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic check_rng(string name, int act, int lo, int hi);
        n_chk++;
        if (act >= lo && act <= hi) n_pass++;
        else $display("FAIL %s: got cycle %0d, expected within [%0d,%0d]", name, act, lo, hi);
    endtask

    function automatic exp_t mk(int kind, int cnt, int nominal);
        exp_t e;
        e.kind = kind;
        e.cnt  = cnt;
        e.lo   = nominal - SLOP_LO;
        e.hi   = nominal + SLOP_HI;
        return e;
    endfunction

    task automatic push(int c, exp_t e);
        if (c == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    task automatic observe(int c, int kind, int cnt);
        exp_t e;
        if ((c == 0 && q0.size() == 0) || (c == 1 && q1.size() == 0)) begin
            n_chk++;
            $display("FAIL ch%0d unexpected event: got kind %0d at cycle %0d, expected none", c, kind, cyc);
            return;
        end
        e = (c == 0) ? q0.pop_front() : q1.pop_front();
        check_eq($sformatf("ch%0d event kind", c), kind, e.kind);
        if (kind == K_TAP || kind == K_START)
            check_eq($sformatf("ch%0d tap_count", c), cnt, e.cnt);
        check_rng($sformatf("ch%0d event time kind %0d", c, kind), cyc, e.lo, e.hi);
        if (kind == K_TAP || kind == K_REL)
            check_eq($sformatf("ch%0d busy at gesture end", c), int'(busy[c]), 0);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!reset_p) begin
                for (int c = 0; c < CH; c++) begin
                    if (tap_valid[c])    observe(c, K_TAP, int'(tap_count[c*CW +: CW]));
                    if (long_start[c])   observe(c, K_START, int'(tap_count[c*CW +: CW]));
                    if (long_repeat[c])  observe(c, K_REP, 0);
                    if (long_release[c]) observe(c, K_REL, 0);
                end
            end
        end
    end

    task automatic wait_us(int us);
        repeat (us * CPU) @(negedge clk);
    endtask

    task automatic set_btn(int c, logic v);
        if (c == 0) b0 = v;
        else b1 = v;
    endtask

    // n presses; if hold, the last press is held with k repeats. press_us / k_fix < 0 mean random.
    task automatic gesture(int c, int n, bit hold, int press_us, int k_fix);
        int t, k, d;
        for (int i = 1; i <= n; i++) begin
            set_btn(c, 1'b1);
            t = cyc;
            if (hold && i == n) begin
                k = (k_fix >= 0) ? k_fix : $urandom_range(0, 3);
                d = HOLD + REP * k + $urandom_range(4, 11);
                push(c, mk(K_START, i, t + HOLD * CPU));
                for (int j = 1; j <= k; j++) push(c, mk(K_REP, 0, t + (HOLD + REP * j) * CPU));
                wait_us(d);
                set_btn(c, 1'b0);
                push(c, mk(K_REL, 0, cyc));
            end else begin
                wait_us((press_us > 0) ? press_us : $urandom_range(4, 40));
                set_btn(c, 1'b0);
                t = cyc;
                if (i == n) push(c, mk(K_TAP, n, (n == MAXT) ? t : t + GAP * CPU));
                else wait_us($urandom_range(4, 14));
            end
        end
        wait_us($urandom_range(30, 40));
    endtask

    initial begin
        reset_p = 1'b1;
        b0 = 1'b0; b1 = 1'b0;
        e0 = 1'b1; e1 = 1'b1;
        repeat (4) @(negedge clk);
        check_eq("reset tap_valid", int'(tap_valid), 0);
        check_eq("reset tap_count", int'(tap_count), 0);
        check_eq("reset long pulses", int'({long_start, long_repeat, long_release}), 0);
        check_eq("reset busy", int'(busy), 0);
        reset_p = 1'b0;
        wait_us(5);

        // Directed: single tap, double tap, triple tap, long hold with repeats.
        gesture(0, 1, 1'b0, 30, -1);
        gesture(0, 2, 1'b0, 10, -1);
        gesture(0, 3, 1'b0, 10, -1);
        gesture(1, 1, 1'b1, 0, 3);

        // 1 us glitches are shorter than the debounce window and must vanish.
        for (int g = 0; g < 4; g++) begin
            b0 = 1'b1; wait_us(1);
            b0 = 1'b0; wait_us(4);
        end
        check_eq("glitch busy", int'(busy[0]), 0);
        gesture(0, 2, 1'b1, 10, 0);

        // en dropped mid-hold on ch0 while ch1 runs a double tap.
        fork
            begin
                b0 = 1'b1;
                push(0, mk(K_START, 1, cyc + HOLD * CPU));
                push(0, mk(K_REP, 0, cyc + (HOLD + REP) * CPU));
                wait_us(72);
                check_eq("held busy before en drop", int'(busy[0]), 1);
                e0 = 1'b0;
                @(negedge clk);
                check_eq("busy after en drop", int'(busy[0]), 0);
                wait_us(10);
                e0 = 1'b1;
                wait_us(10);
                b0 = 1'b0;
                wait_us(30);
                check_eq("busy after re-enable and release", int'(busy[0]), 0);
            end
            gesture(1, 2, 1'b0, 10, -1);
        join

        // Reset while ch0 sits in the inter-tap gap.
        b0 = 1'b1; wait_us(10);
        b0 = 1'b0; wait_us(8);
        check_eq("gap busy before reset", int'(busy[0]), 1);
        reset_p = 1'b1;
        #1;
        check_eq("mid-gap reset busy", int'(busy), 0);
        check_eq("mid-gap reset pulses", int'({tap_valid, long_start, long_repeat, long_release}), 0);
        check_eq("mid-gap reset tap_count", int'(tap_count), 0);
        repeat (3) @(negedge clk);
        reset_p = 1'b0;
        wait_us(5);
        gesture(0, 1, 1'b0, 10, -1);

        // Randomised concurrent gestures on both channels.
        fork
            for (int g = 0; g < 10; g++)
                gesture(0, $urandom_range(1, MAXT), ($urandom_range(0, 2) == 0), 0, -1);
            for (int g = 0; g < 10; g++)
                gesture(1, $urandom_range(1, MAXT), ($urandom_range(0, 2) == 0), 0, -1);
        join

        wait_us(60);
        check_eq("ch0 outstanding expected events", q0.size(), 0);
        check_eq("ch1 outstanding expected events", q1.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
